ps2_text_buffer: RTL and testbench



---
 rtl/ps2_text_buffer_if.sv | 27 ++
 rtl/ps2_text_buffer.sv | 154 +++++++++++++++
 tb/tb_ps2_text_buffer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_text_buffer_if.sv
// rtl/ps2_text_buffer_if.sv - keycode/event, read-port and status bundle for ps2_text_buffer
interface ps2_text_buffer_if #(
    parameter int AW = 5
);
    logic          keycode_ready;
    logic [7:0]    keycode;
    logic          ext;
    logic          make;
    logic [7:0]    ascii;
    logic          clear;
    logic [AW-1:0] raddr;
    logic [7:0]    rdata;
    logic [AW-1:0] cursor;
    logic          shift;
    logic          full;
    logic          busy;

    modport master (
        output keycode_ready, keycode, ext, make, ascii, clear, raddr,
        input  rdata, cursor, shift, full, busy
    );

    modport slave (
        input  keycode_ready, keycode, ext, make, ascii, clear, raddr,
        output rdata, cursor, shift, full, busy
    );
endinterface

// File: rtl/ps2_text_buffer.sv
// rtl/ps2_text_buffer.sv - line-editing text buffer between PS/2 keycodes and the LCD scan port
module ps2_text_buffer #(
    parameter int         COLS = 16,
    parameter int         ROWS = 2,
    parameter int         AW   = 5,
    parameter int         WRAP = 1,
    parameter logic [7:0] FILL = 8'h20
) (
    input  logic               clk,
    input  logic               reset_n,
    ps2_text_buffer_if.slave   bus
);
    localparam int            DEPTH    = COLS * ROWS;
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'((ROWS - 1) * COLS);
    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [7:0]    KC_LSHIFT = 8'h12;
    localparam logic [7:0]    KC_RSHIFT = 8'h59;
    localparam logic [7:0]    KC_BKSP   = 8'h66;
    localparam logic [7:0]    KC_ENTER  = 8'h5A;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_sweep, w_sweep_nxt;
    logic [AW-1:0] r_cursor, w_cursor_nxt;
    logic          r_full, w_full_nxt;
    logic          r_shift;
    logic [7:0]    r_rdata;
    logic [7:0]    r_mem [DEPTH];

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_wdata;
    logic          w_is_shift;
    logic          w_edit;
    logic          w_last_row;
    logic [AW-1:0] w_row_next;
    logic [7:0]    w_char;

    assign w_is_shift = !bus.ext && (bus.keycode == KC_LSHIFT || bus.keycode == KC_RSHIFT);
    assign w_edit     = bus.keycode_ready && bus.make && !bus.ext;
    assign w_last_row = (r_cursor >= LAST_ROW);
    // Start of the following row; truncation on the last row is harmless because it is not used there.
    assign w_row_next = AW'((int'(r_cursor) / COLS + 1) * COLS);
    assign w_char     = (r_shift && bus.ascii >= 8'h61 && bus.ascii <= 8'h7A) ? bus.ascii - 8'h20 : bus.ascii;

    // State, sweep pointer, cursor and full flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_CLEAR;
            r_sweep  <= '0;
            r_cursor <= '0;
            r_full   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sweep  <= w_sweep_nxt;
            r_cursor <= w_cursor_nxt;
            r_full   <= w_full_nxt;
        end
    end

    // Next-state logic and the single RAM write port; clear wins over a same-cycle key.
    always_comb begin
        w_state_nxt  = r_state;
        w_sweep_nxt  = r_sweep;
        w_cursor_nxt = r_cursor;
        w_full_nxt   = r_full;
        w_we         = 1'b0;
        w_waddr      = r_cursor;
        w_wdata      = FILL;
        case (r_state)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_sweep;
                if (bus.clear) begin
                    w_sweep_nxt = '0;
                end else if (r_sweep == LAST) begin
                    w_state_nxt  = S_IDLE;
                    w_sweep_nxt  = '0;
                    w_cursor_nxt = '0;
                    w_full_nxt   = 1'b0;
                end else begin
                    w_sweep_nxt = r_sweep + ONE;
                end
            end
            S_IDLE: begin
                if (bus.clear) begin
                    w_state_nxt = S_CLEAR;
                    w_sweep_nxt = '0;
                end else if (w_edit) begin
                    if (bus.keycode == KC_BKSP) begin
                        if (r_full) begin
                            w_we         = 1'b1;
                            w_waddr      = LAST;
                            w_cursor_nxt = LAST;
                            w_full_nxt   = 1'b0;
                        end else if (r_cursor != '0) begin
                            w_we         = 1'b1;
                            w_waddr      = r_cursor - ONE;
                            w_cursor_nxt = r_cursor - ONE;
                        end
                    end else if (bus.keycode == KC_ENTER) begin
                        if (!w_last_row)
                            w_cursor_nxt = w_row_next;
                        else if (WRAP != 0)
                            w_cursor_nxt = '0;
                        else
                            w_full_nxt = 1'b1;
                    end else if (!w_is_shift && bus.ascii != 8'h00 && !r_full) begin
                        w_we    = 1'b1;
                        w_waddr = r_cursor;
                        w_wdata = w_char;
                        if (r_cursor != LAST)
                            w_cursor_nxt = r_cursor + ONE;
                        else if (WRAP != 0)
                            w_cursor_nxt = '0;
                        else
                            w_full_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Shift is tracked even while the sweep runs so a held key is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_shift <= 1'b0;
        else if (bus.keycode_ready && w_is_shift)
            r_shift <= bus.make;
    end

    // Character RAM write port; contents come from the clear sweep, not reset.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    // Registered read port; a same-address write in this cycle returns the old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_rdata <= 8'h00;
        else
            r_rdata <= r_mem[bus.raddr];
    end

    assign bus.rdata  = r_rdata;
    assign bus.cursor = r_cursor;
    assign bus.shift  = r_shift;
    assign bus.full   = r_full;
    assign bus.busy   = (r_state == S_CLEAR);
endmodule

// File: tb/tb_ps2_text_buffer.sv
// tb/tb_ps2_text_buffer.sv - self-checking bench for ps2_text_buffer in wrap and stop modes
module tb_ps2_text_buffer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    ps2_text_buffer_if #(.AW(5)) if1 ();
    ps2_text_buffer_if #(.AW(5)) if0 ();

    ps2_text_buffer #(.COLS(16), .ROWS(2), .AW(5), .WRAP(1), .FILL(8'h20)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1)
    );
    ps2_text_buffer #(.COLS(16), .ROWS(2), .AW(5), .WRAP(0), .FILL(8'h20)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] kc;
        logic [7:0] asc;
        logic       mk;
        logic       ex;
        logic       wr;
        logic [4:0] wa;
        logic [7:0] wd;
        logic [4:0] c1;
        logic [4:0] c0;
        logic       f0;
        logic       sh;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        logic       which;
        logic [4:0] addr;
    } rd_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp1 [32];
    logic [7:0] exp0 [32];
    rd_t        sbq [$];
    vec_t       tbl [23];

    function automatic vec_t v(input int kc, asc, mk, ex, wr, wa, wd, c1, c0, f0, sh);
        vec_t r;
        r.kc = 8'(kc); r.asc = 8'(asc); r.mk = 1'(mk); r.ex = 1'(ex);
        r.wr = 1'(wr); r.wa = 5'(wa); r.wd = 8'(wd);
        r.c1 = 5'(c1); r.c0 = 5'(c0); r.f0 = 1'(f0); r.sh = 1'(sh);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] kc, input logic [7:0] asc, input logic mk, input logic ex, input logic kr);
        if1.keycode = kc;  if0.keycode = kc;
        if1.ascii = asc;   if0.ascii = asc;
        if1.make = mk;     if0.make = mk;
        if1.ext = ex;      if0.ext = ex;
        if1.keycode_ready = kr;
        if0.keycode_ready = kr;
    endtask

    task automatic send(input logic [7:0] kc, input logic [7:0] asc, input logic mk, input logic ex);
        set_in(kc, asc, mk, ex, 1'b1);
        tick();
        if1.keycode_ready = 1'b0;
        if0.keycode_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        if1.clear = 1'b1; if0.clear = 1'b1;
        tick();
        if1.clear = 1'b0; if0.clear = 1'b0;
    endtask

    task automatic count_busy(input string name, input int want);
        int n = 0;
        while (if1.busy === 1'b1 && n < 200) begin
            n++;
            tick();
            if1.keycode_ready = 1'b0;
            if0.keycode_ready = 1'b0;
        end
        check(name, 32'(n), 32'(want));
        check({name, "_wrap0_idle"}, 32'(if0.busy), 32'd0);
    endtask

    task automatic read_all(input string tag);
        rd_t e;
        for (int a = 0; a < 32; a++) begin
            if1.raddr = 5'(a);
            if0.raddr = 5'(a);
            sbq.push_back('{exp: exp1[a], which: 1'b1, addr: 5'(a)});
            sbq.push_back('{exp: exp0[a], which: 1'b0, addr: 5'(a)});
            tick();
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                check($sformatf("%s_rdata_w%0d_a%0d", tag, e.which, e.addr),
                      32'(e.which ? if1.rdata : if0.rdata), 32'(e.exp));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ch;
        tbl[0]  = v('h1C, 'h61, 1, 0, 1, 0, 'h61,  1,  1, 0, 0);
        tbl[1]  = v('h12, 'h00, 1, 0, 0, 0, 'h00,  1,  1, 0, 1);
        tbl[2]  = v('h1C, 'h61, 1, 0, 1, 1, 'h41,  2,  2, 0, 1);
        tbl[3]  = v('h12, 'h00, 0, 0, 0, 0, 'h00,  2,  2, 0, 0);
        tbl[4]  = v('h32, 'h62, 1, 0, 1, 2, 'h62,  3,  3, 0, 0);
        tbl[5]  = v('h32, 'h62, 0, 0, 0, 0, 'h00,  3,  3, 0, 0);
        tbl[6]  = v('h1C, 'h61, 1, 1, 0, 0, 'h00,  3,  3, 0, 0);
        tbl[7]  = v('h66, 'h00, 1, 0, 1, 2, 'h20,  2,  2, 0, 0);
        tbl[8]  = v('h66, 'h00, 1, 0, 1, 1, 'h20,  1,  1, 0, 0);
        tbl[9]  = v('h66, 'h00, 1, 0, 1, 0, 'h20,  0,  0, 0, 0);
        tbl[10] = v('h66, 'h00, 1, 0, 0, 0, 'h00,  0,  0, 0, 0);
        tbl[11] = v('h59, 'h00, 1, 0, 0, 0, 'h00,  0,  0, 0, 1);
        tbl[12] = v('h16, 'h31, 1, 0, 1, 0, 'h31,  1,  1, 0, 1);
        tbl[13] = v('h59, 'h00, 0, 0, 0, 0, 'h00,  1,  1, 0, 0);
        tbl[14] = v('h12, 'h00, 1, 1, 0, 0, 'h00,  1,  1, 0, 0);
        tbl[15] = v('h12, 'h00, 1, 0, 0, 0, 'h00,  1,  1, 0, 1);
        tbl[16] = v('h1A, 'h7A, 1, 0, 1, 1, 'h5A,  2,  2, 0, 1);
        tbl[17] = v('h54, 'h7B, 1, 0, 1, 2, 'h7B,  3,  3, 0, 1);
        tbl[18] = v('h12, 'h00, 0, 0, 0, 0, 'h00,  3,  3, 0, 0);
        tbl[19] = v('h21, 'h63, 1, 0, 1, 3, 'h63,  4,  4, 0, 0);
        tbl[20] = v('h23, 'h64, 1, 0, 1, 4, 'h64,  5,  5, 0, 0);
        tbl[21] = v('h5A, 'h00, 1, 0, 0, 0, 'h00, 16, 16, 0, 0);
        tbl[22] = v('h5A, 'h00, 1, 0, 0, 0, 'h00,  0, 16, 1, 0);

        set_in(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        if1.clear = 1'b0; if0.clear = 1'b0;
        if1.raddr = '0;   if0.raddr = '0;

        // Reset state
        tick(); tick(); tick();
        check("rst_busy", 32'(if1.busy), 32'd1);
        check("rst_cursor", 32'(if1.cursor), 32'd0);
        check("rst_shift", 32'(if1.shift), 32'd0);
        check("rst_full", 32'(if0.full), 32'd0);
        check("rst_rdata", 32'(if1.rdata), 32'd0);
        check("rst_busy_w0", 32'(if0.busy), 32'd1);

        reset_n = 1'b1;
        count_busy("init_busy_cycles", 32);
        check("init_cursor", 32'(if1.cursor), 32'd0);
        for (int a = 0; a < 32; a++) begin
            exp1[a] = 8'h20;
            exp0[a] = 8'h20;
        end
        read_all("init");

        // Table-driven edits, applied to both modes in lockstep
        for (int i = 0; i < 23; i++) begin
            send(tbl[i].kc, tbl[i].asc, tbl[i].mk, tbl[i].ex);
            check($sformatf("vec%0d_cursor_w1", i), 32'(if1.cursor), 32'(tbl[i].c1));
            check($sformatf("vec%0d_cursor_w0", i), 32'(if0.cursor), 32'(tbl[i].c0));
            check($sformatf("vec%0d_full_w0", i), 32'(if0.full), 32'(tbl[i].f0));
            check($sformatf("vec%0d_full_w1", i), 32'(if1.full), 32'd0);
            check($sformatf("vec%0d_shift", i), 32'(if1.shift), 32'(tbl[i].sh));
            if (tbl[i].wr) begin
                exp1[tbl[i].wa] = tbl[i].wd;
                exp0[tbl[i].wa] = tbl[i].wd;
            end
        end
        read_all("table");

        // Clear, then a key one cycle later must be dropped
        pulse_clear();
        check("clear_busy_now", 32'(if1.busy), 32'd1);
        set_in(8'h1C, 8'h61, 1'b1, 1'b0, 1'b1);
        count_busy("clear_busy_cycles", 32);
        check("clear_cursor_w1", 32'(if1.cursor), 32'd0);
        check("clear_cursor_w0", 32'(if0.cursor), 32'd0);
        check("clear_full_w0", 32'(if0.full), 32'd0);
        for (int a = 0; a < 32; a++) begin
            exp1[a] = 8'h20;
            exp0[a] = 8'h20;
        end
        read_all("clear");

        // Read and write to the same address in one cycle returns old data
        if1.raddr = 5'd0; if0.raddr = 5'd0;
        send(8'h1C, 8'h61, 1'b1, 1'b0);
        check("collide_old_w1", 32'(if1.rdata), 32'h20);
        check("collide_old_w0", 32'(if0.rdata), 32'h20);
        tick();
        check("collide_new_w1", 32'(if1.rdata), 32'h61);
        exp1[0] = 8'h61;
        exp0[0] = 8'h61;

        // Fill to the end: WRAP=1 wraps, WRAP=0 parks with full and drops the 33rd key
        for (int i = 1; i <= 32; i++) begin
            ch = 8'(8'h61 + i % 26);
            send(8'h1C, ch, 1'b1, 1'b0);
            exp1[i % 32] = ch;
            if (i < 32) exp0[i] = ch;
            check($sformatf("fill%0d_cursor_w1", i), 32'(if1.cursor), 32'((i + 1) % 32));
            check($sformatf("fill%0d_cursor_w0", i), 32'(if0.cursor), 32'((i + 1 > 31) ? 31 : i + 1));
            check($sformatf("fill%0d_full_w0", i), 32'(if0.full), 32'(i >= 31));
        end
        send(8'h66, 8'h00, 1'b1, 1'b0);
        check("bs_full_cursor_w0", 32'(if0.cursor), 32'd31);
        check("bs_full_full_w0", 32'(if0.full), 32'd0);
        check("bs_cursor_w1", 32'(if1.cursor), 32'd0);
        exp1[0] = 8'h20;
        exp0[31] = 8'h20;
        read_all("fill");

        // Reset mid-sweep restarts the full sweep
        pulse_clear();
        repeat (10) tick();
        check("sweep_mid_busy", 32'(if1.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("sweep_rst_busy", 32'(if1.busy), 32'd1);
        check("sweep_rst_cursor", 32'(if0.cursor), 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        count_busy("rst_sweep_cycles", 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
